// File: rtl/id_regfile_sb.sv
// Register file for the ID stage: x1..x31 storage, WB write port, two read ports,
// same-cycle write bypass and a load scoreboard that stalls reads of pending loads.
module id_regfile_sb #(
    parameter int DataWidth = 32,
    parameter bit BypassEn  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [4:0]           rf_waddr_wb_i,
    input  logic [DataWidth-1:0] rf_wdata_wb_i,
    input  logic                 rf_we_wb_i,
    input  logic                 ld_done_i,
    input  logic [4:0]           rf_raddr_a_i,
    input  logic                 rf_ren_a_i,
    output logic [DataWidth-1:0] rf_rdata_a_o,
    input  logic [4:0]           rf_raddr_b_i,
    input  logic                 rf_ren_b_i,
    output logic [DataWidth-1:0] rf_rdata_b_o,
    input  logic                 ld_issue_i,
    input  logic [4:0]           ld_rd_i,
    output logic                 stall_ld_o,
    output logic                 sb_busy_o
);

    logic [DataWidth-1:0] regs [31:1];
    logic [31:1]          pending;
    logic [31:1]          set_vec;
    logic [31:1]          clr_vec;

    logic                 wr_en;
    logic                 ld_clr;
    logic                 byp_a;
    logic                 byp_b;
    logic [DataWidth-1:0] mem_a;
    logic [DataWidth-1:0] mem_b;
    logic                 pend_a;
    logic                 pend_b;
    logic                 clr_hit_a;
    logic                 clr_hit_b;
    logic                 haz_a;
    logic                 haz_b;

    assign wr_en  = rf_we_wb_i && (rf_waddr_wb_i != 5'd0);
    assign ld_clr = wr_en && ld_done_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf_waddr_wb_i] <= rf_wdata_wb_i;
        end
    end

    // Stored-value read muxes; address 0 falls through to zero.
    always_comb begin
        mem_a  = '0;
        mem_b  = '0;
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (rf_raddr_a_i == 5'(i)) begin
                mem_a  = regs[i];
                pend_a = pending[i];
            end
            if (rf_raddr_b_i == 5'(i)) begin
                mem_b  = regs[i];
                pend_b = pending[i];
            end
        end
    end

    assign byp_a = BypassEn && wr_en && (rf_waddr_wb_i == rf_raddr_a_i);
    assign byp_b = BypassEn && wr_en && (rf_waddr_wb_i == rf_raddr_b_i);

    assign rf_rdata_a_o = byp_a ? rf_wdata_wb_i : mem_a;
    assign rf_rdata_b_o = byp_b ? rf_wdata_wb_i : mem_b;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < 32; i++) begin
            if (ld_issue_i && ld_rd_i == 5'(i)) begin
                set_vec[i] = 1'b1;
            end
            if (ld_clr && rf_waddr_wb_i == 5'(i)) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // Set is applied after clear so a newer load to the same register wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    assign clr_hit_a = BypassEn && rf_we_wb_i && ld_done_i &&
                       (rf_waddr_wb_i == rf_raddr_a_i);
    assign clr_hit_b = BypassEn && rf_we_wb_i && ld_done_i &&
                       (rf_waddr_wb_i == rf_raddr_b_i);

    assign haz_a = rf_ren_a_i && pend_a && !clr_hit_a;
    assign haz_b = rf_ren_b_i && pend_b && !clr_hit_b;

    assign stall_ld_o = haz_a || haz_b;
    assign sb_busy_o  = |pending;

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed plus randomized bench for id_regfile_sb against an array-based
// register/scoreboard model.
module tb_id_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        ld_done;
    logic [4:0]  raddr_a;
    logic        ren_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic        ren_b;
    logic [31:0] rdata_b;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        stall;
    logic        busy;

    int vectors;
    int miscompares;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    id_regfile_sb #(.DataWidth(32), .BypassEn(1'b1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rf_waddr_wb_i(waddr),
        .rf_wdata_wb_i(wdata),
        .rf_we_wb_i   (we),
        .ld_done_i    (ld_done),
        .rf_raddr_a_i (raddr_a),
        .rf_ren_a_i   (ren_a),
        .rf_rdata_a_o (rdata_a),
        .rf_raddr_b_i (raddr_b),
        .rf_ren_b_i   (ren_b),
        .rf_rdata_b_o (rdata_b),
        .ld_issue_i   (ld_issue),
        .ld_rd_i      (ld_rd),
        .stall_ld_o   (stall),
        .sb_busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && ld_issue) begin
            vectors++;
            assert (stall === 1'b0) else begin
                miscompares++;
                $error("FAIL issue_on_stall obs=%b exp=0", stall);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (rst_n && we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit exp_haz(input logic ren, input logic [4:0] a);
        if (!rst_n || !ren || a == 0) return 1'b0;
        if (we && ld_done && waddr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic bit exp_stall();
        return exp_haz(ren_a, raddr_a) || exp_haz(ren_b, raddr_b);
    endfunction

    function automatic bit exp_busy();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ld,
                         input logic [4:0] ra, input logic rea,
                         input logic [4:0] rb, input logic reb,
                         input logic iss, input logic [4:0] rd);
        we = w; waddr = wa; wdata = wd; ld_done = ld;
        raddr_a = ra; ren_a = rea; raddr_b = rb; ren_b = reb;
        ld_issue = iss; ld_rd = rd;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rdata_a"}, rdata_a, exp_rd(raddr_a));
        chk({tag, ".rdata_b"}, rdata_b, exp_rd(raddr_b));
        chk({tag, ".stall"}, {31'h0, stall}, {31'h0, exp_stall()});
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, exp_busy()});
    endtask

    // Check this cycle's outputs, then advance one edge and update the model.
    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (we && waddr != 0) begin
                m_regs[waddr] = wdata;
                if (ld_done) m_pend[waddr] = 1'b0;
            end
            if (ld_issue && ld_rd != 0) m_pend[ld_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        step("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 1, 5'(31 - i), 1, 0, 0);
            step("read_all");
        end

        drive(1, 0, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0);
        step("wr_x0");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step("rd_x0");
        chk("x0_zero", rdata_a, 32'h0);

        drive(1, 5, 32'h12345678, 0, 5, 1, 5, 1, 0, 0);
        #1;
        chk("bypass_x5", rdata_a, 32'h12345678);
        step("bypass");
        drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step("x5_stored");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step("issue_x7");
        drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        #1;
        chk("x7_stall", {31'h0, stall}, 32'h1);
        chk("x7_busy", {31'h0, busy}, 32'h1);
        step("x7_wait");
        drive(1, 7, 32'hA5A5A5A5, 1, 7, 1, 0, 0, 0, 0);
        #1;
        chk("x7_clr_stall", {31'h0, stall}, 32'h0);
        chk("x7_clr_data", rdata_a, 32'hA5A5A5A5);
        step("x7_clr");
        drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        #1;
        chk("x7_idle_busy", {31'h0, busy}, 32'h0);
        step("x7_idle");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step("issue_x9");
        drive(1, 9, 32'h99, 1, 0, 0, 0, 0, 1, 9);
        step("x9_set_clr");
        drive(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        #1;
        chk("x9_still_stall", {31'h0, stall}, 32'h1);
        step("x9_read");
        drive(1, 9, 32'h999, 1, 0, 0, 9, 1, 0, 0);
        step("x9_clr");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("issue_x0");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        #1;
        chk("x0_no_stall", {31'h0, stall}, 32'h0);
        chk("x0_not_busy", {31'h0, busy}, 32'h0);
        step("x0_read");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        step("issue_x3");
        drive(1, 3, 32'h33, 0, 3, 1, 0, 0, 0, 0);
        #1;
        chk("x3_nonload_stall", {31'h0, stall}, 32'h1);
        step("x3_nonload");
        drive(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        step("x3_persist");
        drive(1, 3, 32'h3333, 1, 0, 0, 0, 0, 0, 0);
        step("x3_clr");

        drive(1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 4);
        step("issue_x4");
        drive(1, 6, 32'h66, 0, 0, 0, 0, 0, 1, 6);
        step("issue_x6");
        drive(0, 0, 0, 0, 4, 1, 6, 1, 0, 0);
        #1;
        chk("x46_pending", {31'h0, stall}, 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_x4", rdata_a, 32'h0);
        chk("rst_x6", rdata_b, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst");

        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            logic [4:0] rb;
            logic [4:0] rd;
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            drive(1'($urandom), wa, $urandom, 1'($urandom), ra,
                  1'($urandom), rb, 1'($urandom), 0, rd);
            if (!exp_stall()) ld_issue = 1'($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Register file that receives the writeback stage's write port and serves the ID stage's two operand read ports.
- Write-to-read bypass lets a same-cycle writeback value reach ID with no extra stall.
- Load scoreboard tracks destinations of loads not yet written back and raises a stall when ID reads one of them.
- Sits between the WB stage (write side) and the ID stage (read side, stall to pipeline control).

Parameters:
- DataWidth, 32, register width in bits.
- BypassEn, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- rf_waddr_wb_i  input  5  write address from WB.
- rf_wdata_wb_i  input  DataWidth  write data from WB.
- rf_we_wb_i  input  1  write enable from WB.
- ld_done_i  input  1  current WB write is load data from the LSU.
- rf_raddr_a_i  input  5  read address, port A.
- rf_ren_a_i  input  1  port A operand used by the instruction in ID.
- rf_rdata_a_o  output  DataWidth  read data, port A.
- rf_raddr_b_i  input  5  read address, port B.
- rf_ren_b_i  input  1  port B operand used by the instruction in ID.
- rf_rdata_b_o  output  DataWidth  read data, port B.
- ld_issue_i  input  1  load leaving ID this cycle (not stalled).
- ld_rd_i  input  5  destination register of the issuing load.
- stall_ld_o  output  1  ID must hold: a used operand is a pending load destination.
- sb_busy_o  output  1  at least one load is pending.

Behaviour:
- Storage is x1..x31, each DataWidth bits.
- x0 has no storage: reads always return 0; writes to x0 are dropped.
- Reset (rst_ni low, asynchronous): all registers clear to 0 and all scoreboard bits clear.
  - Reset outputs: rf_rdata_* = 0, stall_ld_o = 0, sb_busy_o = 0.
  - Reset mid-load discards the pending state; no stall follows reset.
- Write: on the rising edge with rf_we_wb_i = 1 and rf_waddr_wb_i != 0, regs[rf_waddr_wb_i] <= rf_wdata_wb_i.
- Read: combinational, zero latency; rf_rdata_x_o = regs[rf_raddr_x_i].
- Bypass (BypassEn = 1): if rf_we_wb_i = 1, rf_waddr_wb_i == rf_raddr_x_i and rf_raddr_x_i != 0, then rf_rdata_x_o = rf_wdata_wb_i in the same cycle.
  - Ports A and B are bypassed independently; both may bypass at once.
- Scoreboard: pending[31:1], registered.
  - Set: ld_issue_i = 1 and ld_rd_i != 0 sets pending[ld_rd_i] on the next edge.
  - Clear: rf_we_wb_i = 1, ld_done_i = 1 and rf_waddr_wb_i != 0 clears pending[rf_waddr_wb_i] on the next edge.
  - Same register set and cleared in one cycle: set wins (a newer load is outstanding).
  - Different registers: set and clear both apply.
  - A load to x0 is never tracked.
  - Non-load writes (ld_done_i = 0) do not touch the scoreboard.
  - A clear for a register that is not pending has no effect.
- Stall (combinational): stall_ld_o = hazA | hazB.
  - hazX = rf_ren_x_i & pending[rf_raddr_x_i] & ~clr_hit_x.
  - clr_hit_x = BypassEn & rf_we_wb_i & ld_done_i & (rf_waddr_wb_i == rf_raddr_x_i).
  - With BypassEn = 0, the stall holds until the cycle after the clear.
  - Reads of x0 never stall. rf_ren_x_i = 0 never stalls.
- sb_busy_o = |pending (registered state only).
- While stall_ld_o = 1, ID must hold ld_issue_i = 0. Issue on a stalled cycle is illegal and is flagged by a bench assertion.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0; write x0 = 0xDEADBEEF, read x0 -> 0.
- Write x5 = 0x12345678 with raddr_a = 5 in the same cycle -> rdata_a = 0x12345678 that cycle (BypassEn = 1); with BypassEn = 0 -> old value 0, new value next cycle.
- Issue load to x7; next cycle ren_a = 1, raddr_a = 7 -> stall_ld_o = 1, sb_busy_o = 1; LSU write x7 = 0xA5A5A5A5 with ld_done_i -> stall_ld_o = 0 and rdata_a = 0xA5A5A5A5 that cycle; sb_busy_o = 0 next cycle.
- Same-cycle load issue to x9 and LSU clear of x9 -> pending[9] stays 1; read x9 next cycle -> stall_ld_o = 1.
- Load to x0 issued, read x0 -> no stall, sb_busy_o = 0; non-load write to x3 while x3 pending -> stall persists.
- Loads pending on x4 and x6; assert rst_ni low mid-cycle -> immediately stall_ld_o = 0, sb_busy_o = 0, reads of x4/x6 = 0.
